counter_stepper: RTL
====================

# counter_stepper

Initiator for the up/down step handshake used by the counter block. The stepper takes a target value and drives the counter toward it with single-step `up` or `down` requests, waiting for the matching acknowledge after each step. It sits between control logic, which issues `start`/`target`, and the counter, whose `counter`, `upAck` and `downAck` feed back into it. It reports `busy`, a `done` pulse, and a sticky `error` on a protocol violation or an acknowledge timeout.

## Interface
- `SIZE`, 8, width of the target and count values.
- `TIMEOUT`, 16, maximum number of consecutive cycles to wait for an acknowledge; must be ≥ 2.

- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  begin a move to `target`; honoured only when not `busy`.
- `abort`  in  1  cancel the move in progress.
- `target`  in  SIZE  destination value; latched when `start` is accepted.
- `count`  in  SIZE  current counter value, driven from the counter output.
- `upAck`  in  1  step-up acknowledge from the counter.
- `downAck`  in  1  step-down acknowledge from the counter.
- `up`  out  1  step-up request; registered.
- `down`  out  1  step-down request; registered.
- `busy`  out  1  high in any state other than IDLE and ERROR.
- `done`  out  1  one-cycle pulse when `count` equals the latched target.
- `error`  out  1  sticky fault flag; cleared by an accepted `start` or by `reset`.

## Operation
- States:
  - IDLE
  - COMPARE
  - REQ_UP
  - REQ_DOWN
  - ERROR
- Reset values: state IDLE, `up`=0, `down`=0, `done`=0, `error`=0, latched target 0, timeout counter 0.
- IDLE or ERROR, `start`=1: latch `target`, clear `error`, go to COMPARE.
- COMPARE, comparing `count` against the latched target as unsigned values:
  - equal: pulse `done`, go to IDLE.
  - `count` < target: set `up`=1, go to REQ_UP.
  - `count` > target: set `down`=1, go to REQ_DOWN.
- REQ_UP:
  - `upAck`=1: clear `up`, go to COMPARE.
  - `downAck`=1: clear `up`, set `error`, go to ERROR.
  - Otherwise increment the timeout counter. After `TIMEOUT` consecutive cycles with no acknowledge: clear `up`, set `error`, go to ERROR.
- REQ_DOWN: mirror of REQ_UP, with the roles of `upAck` and `downAck` swapped.
- The timeout counter clears on every entry to REQ_UP or REQ_DOWN.
- `up` and `down` are never high together. Each request holds steady until its acknowledge, a fault or `abort`.
- `abort` has priority over every transition other than `reset`. From any busy state it clears `up`/`down` and goes to IDLE with no `done` pulse and `error` unchanged.
- `start` while `busy` is ignored and the target is not re-latched.
- If `start` and `abort` are high together in IDLE, `abort` wins and the state stays IDLE.
- No wrap-around: direction comes from the unsigned compare only. For example, moving from 0xFF to 0x00 takes 255 down steps.
- An external load on the counter is tolerated, because `count` is re-read in every COMPARE.
- `reset` mid-request drops `up`/`down` asynchronously.

## Timing
- Each step takes 3 cycles:
  - request edge;
  - counter increments and asserts `upAck`;
  - stepper sees the acknowledge, drops the request and re-enters COMPARE.
- With `start` sampled at edge 0:
  - the first request goes high at edge 1;
  - after N steps, `done` is high for the cycle following edge 1+3N;
  - for N=0, `done` follows edge 1.
- Dropping the request at the acknowledge edge guarantees that the counter, when it returns to its idle state, sees the request low. No double step occurs.
- The timeout fires at the `TIMEOUT`-th edge spent in a REQ state without an acknowledge.

## Structure
- Shared package holds:
  - the state encoding constants for IDLE, COMPARE, REQ_UP, REQ_DOWN and ERROR;
  - the default `SIZE` and `TIMEOUT` values.
- One sub-module: `ack_watchdog`, a clearable counter of width clog2(`TIMEOUT`+1) with a `clear`/`enable` input and an `expired` output.
- The remaining logic stays in a single state-machine process.

## Test plan
- Counter instance at 5, `target`=8, `start` pulse → exactly three `up` handshakes and no `down`; `count`=8; `done` high for one cycle after edge 10; `busy` low afterward.
- Counter at 0x03, `target`=0x03 → no request; `done` after edge 1.
- Counter at 0xFF, `target`=0x00 → 255 down steps with no wrap; final `count`=0x00.
- Acknowledge stuck low with `TIMEOUT`=4 → `up` drops and `error`=1 after 4 cycles in REQ_UP. A subsequent `start` clears `error` and the move completes.
- `downAck` injected while in REQ_UP → ERROR, `up`=0.
- `abort` during REQ_DOWN → IDLE next edge, `down`=0, no `done`.
- `start` re-asserted while busy with a new `target` → ignored.
- `reset` asserted mid-request → `up`/`down`/`busy` go low immediately.

Source files
------------

// File: rtl/counter_stepper_pkg.sv
// Shared types and defaults for the counter stepper: state encoding and parameter defaults.
package counter_stepper_pkg;

  localparam int DEFAULT_SIZE    = 8;
  localparam int DEFAULT_TIMEOUT = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COMPARE  = 3'd1,
    ST_REQ_UP   = 3'd2,
    ST_REQ_DOWN = 3'd3,
    ST_ERROR    = 3'd4
  } state_t;

  // Busy covers every state that is working toward a target.
  function automatic logic is_busy(input state_t s);
    return (s == ST_COMPARE) || (s == ST_REQ_UP) || (s == ST_REQ_DOWN);
  endfunction

endpackage

// File: rtl/ack_watchdog.sv
// Clearable saturating cycle counter; expired marks the last cycle of the acknowledge window.
module ack_watchdog
  import counter_stepper_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count_r;

  // Wait-cycle counter: cleared outside requests, saturates at the last allowed cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= {W{1'b0}};
    end else if (clear) begin
      count_r <= {W{1'b0}};
    end else if (enable && (count_r != LAST)) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // An edge taken while expired is the TIMEOUT-th edge without an acknowledge.
  assign expired = (count_r == LAST);

endmodule

// File: rtl/counter_stepper.sv
// Drives the counter toward a latched target with single up/down handshakes, reporting busy/done/error.
module counter_stepper
  import counter_stepper_pkg::*;
#(
  parameter int SIZE    = DEFAULT_SIZE,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [SIZE-1:0] target,
  input  logic [SIZE-1:0] count,
  input  logic            upAck,
  input  logic            downAck,
  output logic            up,
  output logic            down,
  output logic            busy,
  output logic            done,
  output logic            error
);

  state_t          state_r, state_nxt_s;
  logic [SIZE-1:0] target_r, target_nxt_s;
  logic            up_r, up_nxt_s;
  logic            down_r, down_nxt_s;
  logic            done_r, done_nxt_s;
  logic            error_r, error_nxt_s;
  logic            busy_r;
  logic            in_req_s;
  logic            expired_s;

  assign in_req_s = (state_r == ST_REQ_UP) || (state_r == ST_REQ_DOWN);

  ack_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (!in_req_s),
    .enable  (in_req_s),
    .expired (expired_s)
  );

  // State and output registers; reset drops any request immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      target_r <= {SIZE{1'b0}};
      up_r     <= 1'b0;
      down_r   <= 1'b0;
      done_r   <= 1'b0;
      error_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      target_r <= target_nxt_s;
      up_r     <= up_nxt_s;
      down_r   <= down_nxt_s;
      done_r   <= done_nxt_s;
      error_r  <= error_nxt_s;
      busy_r   <= is_busy(state_nxt_s);
    end
  end

  // Next-state and output decisions; abort outranks every other transition.
  always_comb begin
    state_nxt_s  = state_r;
    target_nxt_s = target_r;
    up_nxt_s     = up_r;
    down_nxt_s   = down_r;
    done_nxt_s   = 1'b0;
    error_nxt_s  = error_r;

    if (abort) begin
      if (is_busy(state_r)) begin
        state_nxt_s = ST_IDLE;
        up_nxt_s    = 1'b0;
        down_nxt_s  = 1'b0;
      end else begin
        state_nxt_s = state_r;
      end
    end else begin
      case (state_r)
        ST_IDLE, ST_ERROR: begin
          if (start) begin
            target_nxt_s = target;
            error_nxt_s  = 1'b0;
            state_nxt_s  = ST_COMPARE;
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_COMPARE: begin
          // count is re-read here each step, so external loads are followed.
          if (count == target_r) begin
            done_nxt_s  = 1'b1;
            state_nxt_s = ST_IDLE;
          end else if (count < target_r) begin
            up_nxt_s    = 1'b1;
            state_nxt_s = ST_REQ_UP;
          end else begin
            down_nxt_s  = 1'b1;
            state_nxt_s = ST_REQ_DOWN;
          end
        end
        ST_REQ_UP: begin
          if (upAck) begin
            up_nxt_s    = 1'b0;
            state_nxt_s = ST_COMPARE;
          end else if (downAck || expired_s) begin
            up_nxt_s    = 1'b0;
            error_nxt_s = 1'b1;
            state_nxt_s = ST_ERROR;
          end else begin
            state_nxt_s = ST_REQ_UP;
          end
        end
        ST_REQ_DOWN: begin
          if (downAck) begin
            down_nxt_s  = 1'b0;
            state_nxt_s = ST_COMPARE;
          end else if (upAck || expired_s) begin
            down_nxt_s  = 1'b0;
            error_nxt_s = 1'b1;
            state_nxt_s = ST_ERROR;
          end else begin
            state_nxt_s = ST_REQ_DOWN;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          up_nxt_s    = 1'b0;
          down_nxt_s  = 1'b0;
        end
      endcase
    end
  end

  assign up    = up_r;
  assign down  = down_r;
  assign busy  = busy_r;
  assign done  = done_r;
  assign error = error_r;

endmodule
